// File: rtl/regfile_dbg_pkg.sv
// Shared constants and types for the register file debug port.
// Imported by the pointer sub-module and the top level.
package regfile_dbg_pkg;

    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int DW     = 64;
    localparam int ZR_IDX = 31;

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DUMP,
        FIN
    } dbgState_t;

endpackage

// File: rtl/regfile_dbg_ptr.sv
// Register index pointer and remaining-transfer counter.
// The index wraps modulo NREG; the count saturates at NREG on load.
module regfile_dbg_ptr
    import regfile_dbg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] firstIdx,
    input  logic [AW:0]   count,
    output logic [AW-1:0] ptr,
    output logic [AW:0]   rem,
    output logic          isLast,
    output logic          isEmpty
);

    localparam logic [AW:0] MAX_REM = (AW+1)'(NREG);

    logic [AW:0] satCount;

    assign satCount = (count > MAX_REM) ? MAX_REM : count;

    // NREG is a power of two, so the natural AW-bit overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            rem <= '0;
        end else if (load) begin
            ptr <= firstIdx;
            rem <= satCount;
        end else if (step) begin
            ptr <= ptr + AW'(1);
            rem <= rem - (AW+1)'(1);
        end
    end

    assign isLast  = (rem == (AW+1)'(1));
    assign isEmpty = (rem == '0);

endmodule

// File: rtl/regfile_debug_port.sv
// Debug master for the RegisterFile write port and read port A:
// bulk loads a register range from a stream or dumps one to a stream.
module regfile_debug_port
    import regfile_dbg_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Cmd_valid,
    output logic          Cmd_ready,
    input  logic          Cmd_op,
    input  logic [AW-1:0] Cmd_first,
    input  logic [AW:0]   Cmd_count,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [DW-1:0] In_data,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [DW-1:0] Out_data,
    output logic [AW-1:0] Out_index,
    output logic          Out_last,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] RA,
    input  logic [DW-1:0] BusA,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] BusW,
    output logic          RegWr
);

    dbgState_t state, nextState;

    logic [AW-1:0] ptr;
    logic [AW:0]   rem;
    logic          isLast, isEmpty;
    logic          ptrLoad, ptrStep;
    logic          inFire, outFire, outLoad;

    regfile_dbg_ptr uPtr (
        .clk     (Clk),
        .rst     (Reset),
        .load    (ptrLoad),
        .step    (ptrStep),
        .firstIdx(Cmd_first),
        .count   (Cmd_count),
        .ptr     (ptr),
        .rem     (rem),
        .isLast  (isLast),
        .isEmpty (isEmpty)
    );

    assign Cmd_ready = (state == IDLE);
    assign In_ready  = (state == LOAD);
    assign Busy      = (state != IDLE);
    assign Done      = (state == FIN);
    assign RA        = ptr;

    assign inFire  = In_valid && In_ready;
    assign outFire = Out_valid && Out_ready;
    // The output slot refills whenever it is empty or being drained.
    assign outLoad = (state == DUMP) && (!Out_valid || Out_ready) && !isEmpty;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ptrLoad   = 1'b0;
        ptrStep   = 1'b0;
        unique case (state)
            IDLE: begin
                if (Cmd_valid) begin
                    ptrLoad = 1'b1;
                    if (Cmd_count == '0) begin
                        nextState = FIN;
                    end else if (Cmd_op == OP_LOAD) begin
                        nextState = LOAD;
                    end else begin
                        nextState = DUMP;
                    end
                end
            end
            LOAD: begin
                if (inFire) begin
                    ptrStep = 1'b1;
                    if (isLast) begin
                        nextState = FIN;
                    end
                end
            end
            DUMP: begin
                ptrStep = outLoad;
                if (outFire && Out_last) begin
                    nextState = FIN;
                end
            end
            FIN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RW    <= '0;
            BusW  <= '0;
            RegWr <= 1'b0;
        end else begin
            RegWr <= inFire;
            if (inFire) begin
                RW   <= ptr;
                BusW <= In_data;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out_valid <= 1'b0;
            Out_data  <= '0;
            Out_index <= '0;
            Out_last  <= 1'b0;
        end else if (outLoad) begin
            Out_valid <= 1'b1;
            Out_data  <= BusA;
            Out_index <= ptr;
            Out_last  <= isLast;
        end else if (Out_ready && isEmpty) begin
            Out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port with a behavioural RegisterFile attached.
// Table vectors, hand sequences and random commands against an array model.
module tb_regfile_debug_port;
    import regfile_dbg_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Cmd_valid;
    logic          Cmd_ready;
    logic          Cmd_op;
    logic [AW-1:0] Cmd_first;
    logic [AW:0]   Cmd_count;
    logic          In_valid;
    logic          In_ready;
    logic [DW-1:0] In_data;
    logic          Out_valid;
    logic          Out_ready;
    logic [DW-1:0] Out_data;
    logic [AW-1:0] Out_index;
    logic          Out_last;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] RA;
    logic [DW-1:0] BusA;
    logic [AW-1:0] RW;
    logic [DW-1:0] BusW;
    logic          RegWr;

    always #5 Clk = ~Clk;

    regfile_debug_port dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Cmd_valid(Cmd_valid),
        .Cmd_ready(Cmd_ready),
        .Cmd_op   (Cmd_op),
        .Cmd_first(Cmd_first),
        .Cmd_count(Cmd_count),
        .In_valid (In_valid),
        .In_ready (In_ready),
        .In_data  (In_data),
        .Out_valid(Out_valid),
        .Out_ready(Out_ready),
        .Out_data (Out_data),
        .Out_index(Out_index),
        .Out_last (Out_last),
        .Busy     (Busy),
        .Done     (Done),
        .RA       (RA),
        .BusA     (BusA),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr)
    );

    // Behavioural RegisterFile: negedge write, combinational read, r31 = 0.
    logic [DW-1:0] rf [NREG];
    logic          rfInit;

    function automatic logic [DW-1:0] seedVal(int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i * 257);
    endfunction

    always @(negedge Clk) begin
        if (rfInit) begin
            for (int i = 0; i < NREG; i++) rf[i] <= seedVal(i);
        end else if (RegWr && RW != AW'(ZR_IDX)) begin
            rf[RW] <= BusW;
        end
    end

    assign BusA = (RA == AW'(ZR_IDX)) ? '0 : rf[RA];

    // Reference contents as the architecture sees them.
    logic [DW-1:0] mdl [NREG];

    function automatic logic [DW-1:0] expRead(int idx);
        return (idx == ZR_IDX) ? '0 : mdl[idx];
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        op;
        int          first;
        int          count;
        int          nExp;
        int          mode;
        logic [63:0] base;
        logic [63:0] dStep;
    } vecT;

    vecT vecs [11];
    int  pat [6];

    task automatic startCmd(logic op, int first, int count, int nExp);
        @(negedge Clk);
        chk("cmd_ready_idle", 64'(Cmd_ready), 1);
        Cmd_valid = 1'b1;
        Cmd_op    = op;
        Cmd_first = AW'(first);
        Cmd_count = (AW+1)'(count);
        @(posedge Clk);
        #1;
        Cmd_valid = 1'b0;
        chk("busy_after_accept", 64'(Busy), 1);
        chk("done_zero_count", 64'(Done), 64'(nExp == 0));
    endtask

    task automatic finishCmd();
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        @(posedge Clk);
        #1;
        chk("done_one_cycle", 64'(Done), 0);
        chk("idle_after_fin", 64'(Busy), 0);
        chk("regwr_idle", 64'(RegWr), 0);
        chk("outvalid_idle", 64'(Out_valid), 0);
    endtask

    task automatic runLoad(vecT v);
        int k = 0;
        logic sawDone;
        logic vi, hs;
        logic [63:0] d;
        int idx;
        startCmd(1'b1, v.first, v.count, v.nExp);
        sawDone = Done;
        if (sawDone) chk("zero_load_regwr", 64'(RegWr), 0);
        for (int c = 0; c < 4 * v.nExp + 20 && !sawDone; c++) begin
            @(negedge Clk);
            vi = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = vi && In_ready;
            d  = v.base + 64'(k) * v.dStep;
            In_valid = vi;
            In_data  = d;
            @(posedge Clk);
            #1;
            if (hs) begin
                idx = (v.first + k) % NREG;
                chk("load_regwr", 64'(RegWr), 1);
                chk("load_rw", 64'(RW), 64'(idx));
                chk("load_busw", BusW, d);
                if (idx != ZR_IDX) mdl[idx] = d;
                k++;
            end else begin
                chk("load_no_hs_regwr", 64'(RegWr), 0);
            end
            sawDone = Done;
        end
        chk("load_transfers", 64'(k), 64'(v.nExp));
        chk("load_done_seen", 64'(sawDone), 1);
        finishCmd();
    endtask

    task automatic runDump(vecT v, logic poke);
        int k = 0;
        int firstValid = -1;
        logic sawDone;
        logic r, stall;
        logic [DW-1:0] hData;
        logic [AW-1:0] hIdx;
        logic hLast;
        int idx;
        stall = 1'b0;
        hData = '0;
        hIdx  = '0;
        hLast = 1'b0;
        startCmd(1'b0, v.first, v.count, v.nExp);
        sawDone = Done;
        for (int c = 0; c < 4 * v.nExp + 20 && !sawDone; c++) begin
            @(negedge Clk);
            chk("dump_regwr_low", 64'(RegWr), 0);
            unique case (v.mode)
                1:       r = (c < 6) ? 1'(pat[c]) : 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            if (poke && c == 2) begin
                chk("cmd_ready_busy", 64'(Cmd_ready), 0);
                chk("in_ready_dump", 64'(In_ready), 0);
                Cmd_valid = 1'b1;
                Cmd_op    = OP_LOAD;
                Cmd_count = (AW+1)'(3);
                In_valid  = 1'b1;
            end else begin
                Cmd_valid = 1'b0;
            end
            if (Out_valid) begin
                if (firstValid < 0) firstValid = c;
                if (stall) begin
                    chk("stall_data", Out_data, hData);
                    chk("stall_index", 64'(Out_index), 64'(hIdx));
                    chk("stall_last", 64'(Out_last), 64'(hLast));
                end
                if (r) begin
                    idx = (v.first + k) % NREG;
                    chk("dump_data", Out_data, expRead(idx));
                    chk("dump_index", 64'(Out_index), 64'(idx));
                    chk("dump_last", 64'(Out_last), 64'(k == v.nExp - 1));
                    k++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    hData = Out_data;
                    hIdx  = Out_index;
                    hLast = Out_last;
                end
            end
            Out_ready = r;
            @(posedge Clk);
            #1;
            sawDone = Done;
        end
        chk("dump_transfers", 64'(k), 64'(v.nExp));
        chk("dump_done_seen", 64'(sawDone), 1);
        if (v.nExp > 0) chk("dump_latency", 64'(firstValid), 1);
        else chk("zero_dump_outvalid", 64'(Out_valid), 0);
        finishCmd();
    endtask

    initial begin
        vecT rv;
        pat = '{1, 0, 0, 1, 0, 1};
        Reset     = 1'b1;
        rfInit    = 1'b1;
        Cmd_valid = 1'b0;
        Cmd_op    = 1'b0;
        Cmd_first = '0;
        Cmd_count = '0;
        In_valid  = 1'b0;
        In_data   = '0;
        Out_ready = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = seedVal(i);

        repeat (2) @(negedge Clk);
        chk("rst_cmd_ready", 64'(Cmd_ready), 1);
        chk("rst_busy", 64'(Busy), 0);
        chk("rst_in_ready", 64'(In_ready), 0);
        chk("rst_out_valid", 64'(Out_valid), 0);
        chk("rst_out_data", Out_data, 0);
        chk("rst_regwr", 64'(RegWr), 0);
        chk("rst_done", 64'(Done), 0);
        chk("rst_ra_rw", 64'({RA, RW}), 0);
        rfInit = 1'b0;
        Reset  = 1'b0;

        vecs[0]  = '{1'b1, 0, 5, 5, 0, 64'h11, 64'h11};
        vecs[1]  = '{1'b0, 0, 5, 5, 0, 64'h0, 64'h0};
        vecs[2]  = '{1'b1, 30, 4, 4, 0, 64'hA, 64'h1};
        vecs[3]  = '{1'b0, 30, 4, 4, 0, 64'h0, 64'h0};
        vecs[4]  = '{1'b0, 1, 3, 3, 1, 64'h0, 64'h0};
        vecs[5]  = '{1'b1, 7, 0, 0, 0, 64'h0, 64'h0};
        vecs[6]  = '{1'b0, 9, 0, 0, 0, 64'h0, 64'h0};
        vecs[7]  = '{1'b1, 3, 40, 32, 2, 64'h5000, 64'h3};
        vecs[8]  = '{1'b0, 3, 40, 32, 2, 64'h0, 64'h0};
        vecs[9]  = '{1'b0, 31, 1, 1, 0, 64'h0, 64'h0};
        vecs[10] = '{1'b1, 28, 6, 6, 2, 64'hFFFF_FFFF_0000_0000, 64'h77};

        for (int t = 0; t < 11; t++) begin
            if (vecs[t].op) runLoad(vecs[t]);
            else runDump(vecs[t], 1'b0);
        end

        // Reset in the middle of a four-word load after two writes.
        startCmd(1'b1, 0, 4, 4);
        @(negedge Clk);
        In_valid = 1'b1;
        In_data  = 64'h7;
        @(posedge Clk);
        @(negedge Clk);
        In_data = 64'h8;
        @(posedge Clk);
        #1;
        chk("mid_rst_regwr_before", 64'(RegWr), 1);
        chk("mid_rst_rw_before", 64'(RW), 1);
        @(negedge Clk);
        In_valid = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_rst_regwr_async", 64'(RegWr), 0);
        chk("mid_rst_busy", 64'(Busy), 0);
        mdl[0] = 64'h7;
        mdl[1] = 64'h8;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(Cmd_ready), 1);
        rv = '{1'b0, 0, 4, 4, 0, 64'h0, 64'h0};
        runDump(rv, 1'b0);

        // Command and load data offered while a dump is running.
        rv = '{1'b0, 10, 6, 6, 0, 64'h0, 64'h0};
        runDump(rv, 1'b1);

        for (int t = 0; t < 20; t++) begin
            rv.op    = 1'($urandom_range(0, 1));
            rv.first = int'($urandom_range(0, NREG - 1));
            rv.count = int'($urandom_range(0, 40));
            rv.nExp  = (rv.count > NREG) ? NREG : rv.count;
            rv.mode  = 2;
            rv.base  = {$urandom, $urandom};
            rv.dStep = 64'($urandom);
            if (rv.op) runLoad(rv);
            else runDump(rv, 1'b0);
        end

        rv = '{1'b0, 0, 32, 32, 2, 64'h0, 64'h0};
        runDump(rv, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
